// File: rtl/camera_pkg.sv
// camera_pkg: shared FSM state encoding and decimation helpers for the
// camera crop interface.
`default_nettype none

package camera_pkg;

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  localparam logic [1:0] DECIM_1 = 2'b00;
  localparam logic [1:0] DECIM_2 = 2'b01;
  localparam logic [1:0] DECIM_4 = 2'b10;

  // Encoding 2'b11 is reserved and behaves as no decimation.
  function automatic logic [2:0] decim_factor(input logic [1:0] dc);
    case (dc)
      DECIM_1: return 3'd1;
      DECIM_2: return 3'd2;
      DECIM_4: return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/camera_pos_counter.sv
// camera_pos_counter: sync edge detection, column/row position counters with
// saturation, and per-frame line-length consistency tracking.
`default_nettype none

module camera_pos_counter #(
  parameter  int COLS_MAX = 640,
  parameter  int ROWS_MAX = 480,
  localparam int CW       = $clog2(COLS_MAX + 1),
  localparam int RW       = $clog2(ROWS_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          px_en_i,
  input  logic          frame_vld_i,
  input  logic          line_vld_i,
  input  logic          frame_start_i,
  output logic          fv_rise_o,
  output logic          fv_fall_o,
  output logic          lv_fall_o,
  output logic [CW-1:0] col_o,
  output logic [RW-1:0] row_o,
  output logic [RW-1:0] row_end_o,
  output logic [CW-1:0] line_len_o,
  output logic          err_o
);

  logic          fv_q, lv_q;
  logic [CW-1:0] col_q, len_q;
  logic [RW-1:0] row_q;
  logic          have_len_q, err_q;

  logic          w_col_sat, w_row_sat, w_len_chg, w_have_len;
  logic [RW-1:0] w_row_base;

  assign fv_rise_o = px_en_i && frame_vld_i && !fv_q;
  assign fv_fall_o = px_en_i && !frame_vld_i && fv_q;
  assign lv_fall_o = px_en_i && !line_vld_i && lv_q;

  // A new frame restarts rows, line-length reference and error history in
  // the same sample that the FSM enters ACTIVE.
  assign w_row_base = frame_start_i ? '0 : row_q;
  assign w_have_len = have_len_q && !frame_start_i;

  assign w_col_sat = px_en_i && line_vld_i && (col_q == CW'(COLS_MAX));
  assign w_row_sat = lv_fall_o && (w_row_base == RW'(ROWS_MAX));
  assign w_len_chg = lv_fall_o && w_have_len && (col_q != len_q);

  assign col_o      = col_q;
  assign row_o      = w_row_base;
  assign row_end_o  = (lv_fall_o && !w_row_sat) ? w_row_base + 1'b1 : w_row_base;
  assign line_len_o = col_q;
  assign err_o      = (err_q && !frame_start_i) || w_col_sat || w_row_sat || w_len_chg;

  always_ff @(posedge clk) begin
    if (rst) begin
      fv_q       <= 1'b0;
      lv_q       <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      len_q      <= '0;
      have_len_q <= 1'b0;
      err_q      <= 1'b0;
    end else if (px_en_i) begin
      fv_q       <= frame_vld_i;
      lv_q       <= line_vld_i;
      row_q      <= row_end_o;
      err_q      <= err_o;
      have_len_q <= w_have_len || lv_fall_o;
      if (lv_fall_o && !w_have_len) begin
        len_q <= col_q;
      end
      if (lv_fall_o) begin
        col_q <= '0;
      end else if (line_vld_i && !w_col_sat) begin
        col_q <= col_q + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/camera_crop_if.sv
// camera_crop_if: frames camera pixels, crops them to a latched window with
// optional 2x/4x decimation, and emits sof/eol/eof markers and frame status.
`default_nettype none

module camera_crop_if #(
  parameter  int DW       = 8,
  parameter  int COLS_MAX = 640,
  parameter  int ROWS_MAX = 480,
  localparam int CW       = $clog2(COLS_MAX + 1),
  localparam int RW       = $clog2(ROWS_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          px_en,
  input  logic [DW-1:0] pixel_dat,
  input  logic          frame_vld,
  input  logic          line_vld,
  input  logic [CW-1:0] crop_x0,
  input  logic [CW-1:0] crop_x1,
  input  logic [RW-1:0] crop_y0,
  input  logic [RW-1:0] crop_y1,
  input  logic [1:0]    decim,
  output logic [DW-1:0] o_dat,
  output logic          o_vld,
  output logic          sof,
  output logic          eol,
  output logic          eof,
  output logic [CW-1:0] num_cols,
  output logic [RW-1:0] num_rows,
  output logic          frame_err
);

  import camera_pkg::*;

  state_t        state_q, state_d;
  logic          w_frame_start, w_frame_end;

  logic          w_fv_rise, w_fv_fall, w_lv_fall, w_cnt_err;
  logic [CW-1:0] w_col, w_line_len;
  logic [RW-1:0] w_row, w_row_end;

  logic [CW-1:0] x0_q, x1_q;
  logic [RW-1:0] y0_q, y1_q;
  logic [1:0]    decim_q;
  logic          sof_seen_q, eof_seen_q;

  logic [DW-1:0] dat_q;
  logic          vld_q, sof_q, eol_q, eof_q, err_q;
  logic [CW-1:0] num_cols_q;
  logic [RW-1:0] num_rows_q;

  camera_pos_counter #(
    .COLS_MAX (COLS_MAX),
    .ROWS_MAX (ROWS_MAX)
  ) u_pos (
    .clk           (clk),
    .rst           (rst),
    .px_en_i       (px_en),
    .frame_vld_i   (frame_vld),
    .line_vld_i    (line_vld),
    .frame_start_i (w_frame_start),
    .fv_rise_o     (w_fv_rise),
    .fv_fall_o     (w_fv_fall),
    .lv_fall_o     (w_lv_fall),
    .col_o         (w_col),
    .row_o         (w_row),
    .row_end_o     (w_row_end),
    .line_len_o    (w_line_len),
    .err_o         (w_cnt_err)
  );

  always_comb begin
    state_d       = state_q;
    w_frame_start = 1'b0;
    w_frame_end   = 1'b0;
    case (state_q)
      ST_SYNC: begin
        if (px_en && !frame_vld) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (w_fv_rise) begin
          state_d       = ST_ACTIVE;
          w_frame_start = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (w_fv_fall) begin
          state_d     = ST_ARMED;
          w_frame_end = 1'b1;
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  // The frame-start sample itself may carry a pixel, so it must already see
  // the freshly presented window rather than the stale latched one.
  logic [CW-1:0] w_x0, w_x1;
  logic [RW-1:0] w_y0, w_y1;
  logic [2:0]    w_d;
  logic [1:0]    w_mask, w_col_lo, w_row_lo;
  logic          w_bad, w_pix, w_in_x, w_in_y, w_hit, w_eol, w_eof, w_synth;

  assign w_x0 = w_frame_start ? crop_x0 : x0_q;
  assign w_x1 = w_frame_start ? crop_x1 : x1_q;
  assign w_y0 = w_frame_start ? crop_y0 : y0_q;
  assign w_y1 = w_frame_start ? crop_y1 : y1_q;
  assign w_d  = decim_factor(w_frame_start ? decim : decim_q);

  assign w_bad    = (w_x1 < w_x0) || (w_y1 < w_y0);
  assign w_mask   = w_d[1:0] - 2'd1;
  assign w_col_lo = w_col[1:0] - w_x0[1:0];
  assign w_row_lo = w_row[1:0] - w_y0[1:0];

  assign w_pix  = px_en && frame_vld && line_vld && ((state_q == ST_ACTIVE) || w_frame_start);
  assign w_in_x = (w_col >= w_x0) && (w_col <= w_x1) && ((w_col_lo & w_mask) == 2'b00);
  assign w_in_y = (w_row >= w_y0) && (w_row <= w_y1) && ((w_row_lo & w_mask) == 2'b00);
  assign w_hit  = w_pix && !w_bad && w_in_x && w_in_y;

  assign w_eol   = ({1'b0, w_col} + (CW+1)'(w_d)) > {1'b0, w_x1};
  assign w_eof   = w_eol && (({1'b0, w_row} + (RW+1)'(w_d)) > {1'b0, w_y1});
  assign w_synth = w_frame_end && sof_seen_q && !eof_seen_q;

  always_ff @(posedge clk) begin
    vld_q <= 1'b0;
    sof_q <= 1'b0;
    eol_q <= 1'b0;
    eof_q <= 1'b0;
    if (rst) begin
      state_q    <= ST_SYNC;
      x0_q       <= '0;
      x1_q       <= '0;
      y0_q       <= '0;
      y1_q       <= '0;
      decim_q    <= DECIM_1;
      sof_seen_q <= 1'b0;
      eof_seen_q <= 1'b0;
      dat_q      <= '0;
      num_cols_q <= '0;
      num_rows_q <= '0;
      err_q      <= 1'b0;
    end else if (px_en) begin
      state_q <= state_d;
      if (w_frame_start) begin
        x0_q       <= crop_x0;
        x1_q       <= crop_x1;
        y0_q       <= crop_y0;
        y1_q       <= crop_y1;
        decim_q    <= decim;
        sof_seen_q <= 1'b0;
        eof_seen_q <= 1'b0;
      end
      if (w_hit) begin
        dat_q      <= pixel_dat;
        vld_q      <= 1'b1;
        sof_q      <= w_frame_start || !sof_seen_q;
        eol_q      <= w_eol;
        eof_q      <= w_eof;
        sof_seen_q <= 1'b1;
        if (w_eof) eof_seen_q <= 1'b1;
      end
      if (w_synth) eof_q <= 1'b1;
      if (w_lv_fall) num_cols_q <= w_line_len;
      if (w_frame_end) begin
        num_rows_q <= w_row_end;
        err_q      <= w_cnt_err || w_synth || w_bad;
      end
    end
  end

  assign o_dat     = dat_q;
  assign o_vld     = vld_q;
  assign sof       = sof_q;
  assign eol       = eol_q;
  assign eof       = eof_q;
  assign num_cols  = num_cols_q;
  assign num_rows  = num_rows_q;
  assign frame_err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_camera_crop_if.sv
// tb_camera_crop_if: directed 16x12 frames through camera_crop_if, checking
// every sample's outputs one clock after acceptance plus per-frame status.
`default_nettype none

module tb_camera_crop_if;

  localparam int DW = 8;
  localparam int CW = 10;
  localparam int RW = 9;
  localparam int NC = 16;
  localparam int NR = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          px_en;
  logic [DW-1:0] pixel_dat;
  logic          frame_vld, line_vld;
  logic [CW-1:0] crop_x0, crop_x1;
  logic [RW-1:0] crop_y0, crop_y1;
  logic [1:0]    decim;
  logic [DW-1:0] o_dat;
  logic          o_vld, sof, eol, eof;
  logic [CW-1:0] num_cols;
  logic [RW-1:0] num_rows;
  logic          frame_err;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  bit gap_en   = 0;

  camera_crop_if dut (
    .clk       (clk),
    .rst       (rst),
    .px_en     (px_en),
    .pixel_dat (pixel_dat),
    .frame_vld (frame_vld),
    .line_vld  (line_vld),
    .crop_x0   (crop_x0),
    .crop_x1   (crop_x1),
    .crop_y0   (crop_y0),
    .crop_y1   (crop_y1),
    .decim     (decim),
    .o_dat     (o_dat),
    .o_vld     (o_vld),
    .sof       (sof),
    .eol       (eol),
    .eof       (eof),
    .num_cols  (num_cols),
    .num_rows  (num_rows),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One accepted sample, optionally preceded by px_en=0 gap cycles carrying
  // garbage on the qualified inputs.
  task automatic smp(input logic fv, input logic lv, input logic [DW-1:0] dat,
                     input logic ev, input logic es, input logic el,
                     input logic ef, input logic synth);
    if (gap_en) begin
      repeat ($urandom_range(0, 2)) begin
        px_en     = 1'b0;
        frame_vld = 1'($urandom_range(0, 1));
        line_vld  = 1'($urandom_range(0, 1));
        pixel_dat = DW'($urandom_range(0, 255));
        @(posedge clk);
        @(negedge clk);
        chk("gap_vld", 32'(o_vld), 32'(0));
        chk("gap_eof", 32'(eof), 32'(0));
      end
    end
    px_en     = 1'b1;
    frame_vld = fv;
    line_vld  = lv;
    pixel_dat = dat;
    @(posedge clk);
    @(negedge clk);
    px_en = 1'b0;
    chk("o_vld", 32'(o_vld), 32'(ev));
    if (o_vld) n_out++;
    if (ev) begin
      chk("o_dat", 32'(o_dat), 32'(dat));
      chk("sof", 32'(sof), 32'(es));
      chk("eol", 32'(eol), 32'(el));
      chk("eof", 32'(eof), 32'(ef));
    end else begin
      chk("eof_novld", 32'(eof), 32'(synth));
    end
  endtask

  task automatic run_frame(input int x0, input int x1, input int y0, input int y1,
                           input logic [1:0] dc, input bit chg, input int rst_row,
                           input int exp_n, input logic exp_err, input int exp_rows);
    int  d;
    bit  act, sofs, eofs, bad, hit, el, ef;
    d = (dc == 2'b01) ? 2 : (dc == 2'b10) ? 4 : 1;
    crop_x0 = CW'(x0);
    crop_x1 = CW'(x1);
    crop_y0 = RW'(y0);
    crop_y1 = RW'(y1);
    decim   = dc;
    act  = 1;
    sofs = 0;
    eofs = 0;
    bad  = (x1 < x0) || (y1 < y0);
    n_out = 0;
    smp(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    smp(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int r = 0; r < NR; r++) begin
      if (r == rst_row) begin
        px_en = 1'b0;
        rst   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_vld", 32'(o_vld), 32'(0));
        chk("rst_num_cols", 32'(num_cols), 32'(0));
        chk("rst_num_rows", 32'(num_rows), 32'(0));
        chk("rst_frame_err", 32'(frame_err), 32'(0));
        act = 0;
      end
      if (chg && r == 1) begin
        crop_x0 = '0;
        crop_x1 = CW'(NC - 1);
        crop_y0 = '0;
        crop_y1 = RW'(NR - 1);
        decim   = 2'b00;
      end
      smp(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      smp(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < NC; c++) begin
        hit = act && !bad && c >= x0 && c <= x1 && r >= y0 && r <= y1 &&
              ((c - x0) % d == 0) && ((r - y0) % d == 0);
        el  = hit && (c + d > x1);
        ef  = el && (r + d > y1);
        smp(1'b1, 1'b1, DW'(r * 16 + c), hit, hit && !sofs, el, ef, 1'b0);
        if (hit) sofs = 1;
        if (ef) eofs = 1;
      end
    end
    smp(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    smp(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, act && sofs && !eofs);
    smp(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("n_out", 32'(n_out), 32'(exp_n));
    chk("num_cols", 32'(num_cols), 32'(NC));
    chk("num_rows", 32'(num_rows), 32'(exp_rows));
    chk("frame_err", 32'(frame_err), 32'(exp_err));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    px_en     = 1'b0;
    pixel_dat = '0;
    frame_vld = 1'b0;
    line_vld  = 1'b0;
    crop_x0   = '0;
    crop_x1   = '0;
    crop_y0   = '0;
    crop_y1   = '0;
    decim     = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_o_vld", 32'(o_vld), 32'(0));
    chk("reset_o_dat", 32'(o_dat), 32'(0));
    chk("reset_sof", 32'(sof), 32'(0));
    chk("reset_eol", 32'(eol), 32'(0));
    chk("reset_eof", 32'(eof), 32'(0));
    chk("reset_num_cols", 32'(num_cols), 32'(0));
    chk("reset_num_rows", 32'(num_rows), 32'(0));
    chk("reset_frame_err", 32'(frame_err), 32'(0));
    rst = 1'b0;

    // full window
    run_frame(0, 15, 0, 11, 2'b00, 0, -1, 192, 1'b0, 12);
    // decimated sub-window; crop inputs changed mid-frame must be ignored
    run_frame(2, 9, 3, 6, 2'b01, 1, -1, 8, 1'b0, 12);
    // oversize window: clipped, eof synthesized at frame end
    run_frame(0, 31, 0, 31, 2'b00, 0, -1, 192, 1'b1, 12);
    // reset at row 5: rows 0..4 only, frame not reported
    run_frame(0, 15, 0, 11, 2'b00, 0, 5, 80, 1'b0, 0);
    run_frame(0, 15, 0, 11, 2'b00, 0, -1, 192, 1'b0, 12);
    // inverted window
    run_frame(10, 4, 0, 11, 2'b00, 0, -1, 0, 1'b1, 12);
    // random px_en gaps
    gap_en = 1;
    run_frame(2, 9, 3, 6, 2'b01, 0, -1, 8, 1'b0, 12);
    run_frame(0, 15, 0, 11, 2'b10, 0, -1, 12, 1'b0, 12);
    run_frame(0, 15, 0, 11, 2'b00, 0, -1, 192, 1'b0, 12);
    gap_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
